// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and pixel fetch.
// The generator drives the counts and strobes; the consumer drives enable.
interface vga_timing_gen_if #(
    parameter int CW = 16
) ();
    logic          enable;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          hsync;
    logic          vsync;
    logic          display_en;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          line_start;
    logic          frame_start;

    modport master (
        input  enable,
        output h_count, v_count, hsync, vsync, display_en,
        output pixel_x, pixel_y, line_start, frame_start
    );

    modport slave (
        output enable,
        input  h_count, v_count, hsync, vsync, display_en,
        input  pixel_x, pixel_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters with registered syncs,
// display enable, pixel coordinates and line/frame strobes.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 16
) (
    input  logic              clk_25Mhz,
    input  logic              rst_n,
    vga_timing_gen_if.master  vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_q;
    logic [CW-1:0] v_q;
    logic [CW-1:0] h_n;
    logic [CW-1:0] v_n;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_act;
    logic          vs_act;
    logic          de_n;

    logic          hsync_q;
    logic          vsync_q;
    logic          de_q;
    logic [CW-1:0] px_q;
    logic [CW-1:0] py_q;
    logic          ls_q;
    logic          fs_q;

    // Next-state counts and the output decode taken from them
    always_comb begin
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        h_n    = h_wrap ? '0 : h_q + 1'b1;
        v_n    = v_q;
        if (h_wrap) begin
            v_n = v_wrap ? '0 : v_q + 1'b1;
        end
        hs_act = (h_n >= HS_START) && (h_n < HS_END);
        vs_act = (v_n >= VS_START) && (v_n < VS_END);
        de_n   = (h_n < H_VIS) && (v_n < V_VIS);
    end

    // Counter and output registers; everything freezes when disabled
    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (vga.enable) begin
            h_q     <= h_n;
            v_q     <= v_n;
            hsync_q <= hs_act ? HS_POL : ~HS_POL;
            vsync_q <= vs_act ? VS_POL : ~VS_POL;
            de_q    <= de_n;
            px_q    <= de_n ? h_n : '0;
            py_q    <= de_n ? v_n : '0;
            ls_q    <= h_wrap;
            fs_q    <= h_wrap && v_wrap;
        end else begin
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end
    end

    assign vga.h_count     = h_q;
    assign vga.v_count     = v_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.display_en  = de_q;
    assign vga.pixel_x     = px_q;
    assign vga.pixel_y     = py_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny
// 8x6 instance, both checked every cycle against a position model.
module tb_vga_timing_gen;
    logic clk;
    logic rst_d;
    logic rst_s;

    int errors = 0;
    int checks = 0;

    vga_timing_gen_if #(.CW(16)) bd ();
    vga_timing_gen_if #(.CW(8))  bs ();

    vga_timing_gen #(.CW(16)) dut_d (
        .clk_25Mhz (clk),
        .rst_n     (rst_d),
        .vga       (bd)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CW (8)
    ) dut_s (
        .clk_25Mhz (clk),
        .rst_n     (rst_s),
        .vga       (bs)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    typedef struct {
        int h; int v; int hs; int vs; int de;
        int px; int py; int ls; int fs;
    } exp_t;

    // Outputs as a function of how many enabled edges have occurred
    // since reset (t) and whether the latest edge was enabled.
    function automatic exp_t model(longint t, bit ee,
                                   int ha, int hf, int hw, int hb,
                                   int va, int vf, int vw, int vb,
                                   int hp, int vp);
        exp_t r;
        int ht = ha + hf + hw + hb;
        int vt = va + vf + vw + vb;
        longint idx;
        if (t == 0) begin
            r.h = ht - 1; r.v = vt - 1;
            r.hs = 1 - hp; r.vs = 1 - vp;
            r.de = 0; r.px = 0; r.py = 0; r.ls = 0; r.fs = 0;
            return r;
        end
        idx = t - 1;
        r.h  = int'(idx % ht);
        r.v  = int'((idx / ht) % vt);
        r.hs = (r.h >= ha + hf && r.h < ha + hf + hw) ? hp : 1 - hp;
        r.vs = (r.v >= va + vf && r.v < va + vf + vw) ? vp : 1 - vp;
        r.de = (r.h < ha && r.v < va) ? 1 : 0;
        r.px = r.de ? r.h : 0;
        r.py = r.de ? r.v : 0;
        r.ls = (ee && r.h == 0) ? 1 : 0;
        r.fs = (ee && r.h == 0 && r.v == 0) ? 1 : 0;
        return r;
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         name, act, exp, $time);
        end
    endtask

    longint t_d = 0;
    longint t_s = 0;
    bit     ee_d = 0;
    bit     ee_s = 0;

    // Model position trackers follow the same async reset as the DUTs
    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) begin
            t_d = 0; ee_d = 0;
        end else begin
            ee_d = bd.enable;
            if (bd.enable) t_d = t_d + 1;
        end
    end

    always @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            t_s = 0; ee_s = 0;
        end else begin
            ee_s = bs.enable;
            if (bs.enable) t_s = t_s + 1;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        exp_t e;
        e = model(t_d, ee_d, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0);
        check("d_h",  bd.h_count,     e.h);
        check("d_v",  bd.v_count,     e.v);
        check("d_hs", bd.hsync,       e.hs);
        check("d_vs", bd.vsync,       e.vs);
        check("d_de", bd.display_en,  e.de);
        check("d_px", bd.pixel_x,     e.px);
        check("d_py", bd.pixel_y,     e.py);
        check("d_ls", bd.line_start,  e.ls);
        check("d_fs", bd.frame_start, e.fs);
        e = model(t_s, ee_s, 4, 1, 2, 1, 3, 1, 1, 1, 1, 1);
        check("s_h",  bs.h_count,     e.h);
        check("s_v",  bs.v_count,     e.v);
        check("s_hs", bs.hsync,       e.hs);
        check("s_vs", bs.vsync,       e.vs);
        check("s_de", bs.display_en,  e.de);
        check("s_px", bs.pixel_x,     e.px);
        check("s_py", bs.pixel_y,     e.py);
        check("s_ls", bs.line_start,  e.ls);
        check("s_fs", bs.frame_start, e.fs);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic seq_default();
        int de_cnt = 0;
        int hs_lo  = 0;
        for (int i = 0; i < 800; i++) begin
            de_cnt += int'(bd.display_en);
            hs_lo  += int'(!bd.hsync);
            step();
        end
        check("line_de_cycles", de_cnt, 640);
        check("line_hs_low", hs_lo, 96);
        check("line_period_h", bd.h_count, 0);
        check("line_period_ls", bd.line_start, 1);
        check("line_period_v", bd.v_count, 1);
        repeat (7300) step();
        check("pre_hold_h", bd.h_count, 100);
        check("pre_hold_v", bd.v_count, 10);
        bd.enable = 1'b0;
        for (int i = 0; i < 37; i++) begin
            step();
            check("hold_h", bd.h_count, 100);
            check("hold_ls", bd.line_start, 0);
        end
        bd.enable = 1'b1;
        step();
        check("resume_h", bd.h_count, 101);
        check("resume_v", bd.v_count, 10);
        rst_d = 1'b0;
        #1;
        check("arst_h", bd.h_count, 799);
        check("arst_v", bd.v_count, 524);
        check("arst_hs", bd.hsync, 1);
        check("arst_vs", bd.vsync, 1);
        check("arst_de", bd.display_en, 0);
        step();
        step();
        rst_d = 1'b1;
        step();
        check("post_rst_fs", bd.frame_start, 1);
        check("post_rst_h", bd.h_count, 0);
        repeat (300) step();
    endtask

    task automatic seq_small();
        int n = 0;
        int hs_hi = 0;
        int vs_hi = 0;
        int vs_bad = 0;
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            hs_hi += int'(bs.hsync);
            vs_hi += int'(bs.vsync);
            if (bs.vsync && bs.v_count != 4) vs_bad++;
            step();
            n++;
            if (bs.frame_start) begin
                seen = 1;
                break;
            end
        end
        check("small_fs_seen", seen, 1);
        check("small_frame_len", n, 48);
        check("small_hs_high", hs_hi, 12);
        check("small_vs_high", vs_hi, 8);
        check("small_vs_line", vs_bad, 0);
        for (int i = 0; i < 3000; i++) begin
            bs.enable = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_s = 1'b0;
                step();
                rst_s = 1'b1;
            end
            step();
        end
    endtask

    initial begin
        rst_d = 1'b0;
        rst_s = 1'b0;
        bd.enable = 1'b0;
        bs.enable = 1'b0;
        repeat (3) step();
        check("rst_h", bd.h_count, 799);
        check("rst_v", bd.v_count, 524);
        check("rst_hs", bd.hsync, 1);
        check("rst_de", bd.display_en, 0);
        rst_d = 1'b1;
        rst_s = 1'b1;
        step();
        bd.enable = 1'b1;
        bs.enable = 1'b1;
        step();
        check("first_h", bd.h_count, 0);
        check("first_v", bd.v_count, 0);
        check("first_fs", bd.frame_start, 1);
        check("first_ls", bd.line_start, 1);
        check("first_de", bd.display_en, 1);
        check("s_first_fs", bs.frame_start, 1);
        fork
            seq_default();
            seq_small();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
